pwm_carrier_dt: RTL

Three-phase center-aligned PWM carrier with dead-time insertion, directly downstream of the space-vector modulator. It takes per-phase duty words, compares them against a shared triangular carrier, and drives complementary high/low gate signals for the inverter bridge. Duty and dead-time updates are double-buffered so they take effect only at the carrier valley, and the high and low gates of a leg are never asserted together.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_carrier_dt_deadtime_unit.sv | 57 +++++
 rtl/pwm_carrier_dt.sv | 112 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the three-phase center-aligned PWM carrier.
package pwm_pkg;

    localparam int PWM_N    = 8;
    localparam int PWM_DT_W = 6;

    function automatic int pmax(input int n);
        return (32'sd1 <<< n) - 32'sd1;
    endfunction

    function automatic int period(input int n);
        return 32'sd2 * pmax(n);
    endfunction

    localparam int PWM_PMAX   = pmax(PWM_N);
    localparam int PWM_PERIOD = period(PWM_N);

    typedef struct packed {
        logic [PWM_N-1:0] a;
        logic [PWM_N-1:0] b;
        logic [PWM_N-1:0] c;
    } duty3_t;

    typedef struct packed {
        logic h;
        logic l;
    } leg_t;

endpackage

// File: rtl/pwm_carrier_dt_deadtime_unit.sv
// One inverter leg: turns a raw compare into complementary gates with dead time.
module deadtime_unit
    import pwm_pkg::*;
#(
    parameter int DT_W = PWM_DT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            h,
    output logic            l
);

    logic            raw_prev_r;
    logic [DT_W-1:0] dt_cnt_r;
    logic [DT_W-1:0] dt_cnt_s;
    leg_t            leg_r;

    // Next dead-time count: any raw edge reloads, otherwise run down to zero
    always_comb begin
        dt_cnt_s = dt_cnt_r;
        if (raw != raw_prev_r) begin
            dt_cnt_s = dead_time;
        end else if (dt_cnt_r != {DT_W{1'b0}}) begin
            dt_cnt_s = dt_cnt_r - DT_W'(1'b1);
        end else begin
            dt_cnt_s = {DT_W{1'b0}};
        end
    end

    // Edge history, count and gates; both gates stay low while the count is non-zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_prev_r <= 1'b0;
            dt_cnt_r   <= {DT_W{1'b0}};
            leg_r      <= '{h: 1'b0, l: 1'b0};
        end else if (!enable) begin
            raw_prev_r <= 1'b0;
            dt_cnt_r   <= {DT_W{1'b0}};
            leg_r      <= '{h: 1'b0, l: 1'b0};
        end else begin
            raw_prev_r <= raw;
            dt_cnt_r   <= dt_cnt_s;
            if (dt_cnt_s == {DT_W{1'b0}}) begin
                leg_r <= '{h: raw, l: ~raw};
            end else begin
                leg_r <= '{h: 1'b0, l: 1'b0};
            end
        end
    end

    assign h = leg_r.h;
    assign l = leg_r.l;

endmodule

// File: rtl/pwm_carrier_dt.sv
// Triangular carrier, valley-synchronous double-buffered duty/dead-time, three gated legs.
module pwm_carrier_dt
    import pwm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PWM_N-1:0]    duty_a,
    input  logic [PWM_N-1:0]    duty_b,
    input  logic [PWM_N-1:0]    duty_c,
    input  logic                duty_valid,
    input  logic [PWM_DT_W-1:0] dead_time,
    output logic                ah,
    output logic                al,
    output logic                bh,
    output logic                bl,
    output logic                ch,
    output logic                cl,
    output logic                sync
);

    localparam int N    = PWM_N;
    localparam int DT_W = PWM_DT_W;
    localparam logic [N-1:0] CNT_MAX = N'(PWM_PMAX);

    logic [N-1:0]    cnt_r;
    logic            dir_up_r;
    duty3_t          duty_in_s;
    duty3_t          shadow_r;
    duty3_t          active_r;
    logic [DT_W-1:0] shadow_dt_r;
    logic [DT_W-1:0] active_dt_r;
    logic            valley_s;
    logic            sync_r;
    logic [2:0]      raw_s;

    assign duty_in_s = '{a: duty_a, b: duty_b, c: duty_c};
    assign valley_s  = enable && (cnt_r == {N{1'b0}});

    // Up/down carrier; parked at the valley while disabled so restart begins there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {N{1'b0}};
            dir_up_r <= 1'b1;
        end else if (!enable) begin
            cnt_r    <= {N{1'b0}};
            dir_up_r <= 1'b1;
        end else if (dir_up_r) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r    <= CNT_MAX - N'(1'b1);
                dir_up_r <= 1'b0;
            end else begin
                cnt_r    <= cnt_r + N'(1'b1);
            end
        end else begin
            if (cnt_r == N'(1'b1)) begin
                cnt_r    <= {N{1'b0}};
                dir_up_r <= 1'b1;
            end else begin
                cnt_r    <= cnt_r - N'(1'b1);
            end
        end
    end

    // Shadow takes every write; active follows at the valley, bypassing shadow on a same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r    <= '{a: {N{1'b0}}, b: {N{1'b0}}, c: {N{1'b0}}};
            active_r    <= '{a: {N{1'b0}}, b: {N{1'b0}}, c: {N{1'b0}}};
            shadow_dt_r <= {DT_W{1'b0}};
            active_dt_r <= {DT_W{1'b0}};
            sync_r      <= 1'b0;
        end else begin
            if (duty_valid) begin
                shadow_r    <= duty_in_s;
                shadow_dt_r <= dead_time;
            end else begin
                shadow_r    <= shadow_r;
                shadow_dt_r <= shadow_dt_r;
            end
            if (valley_s) begin
                active_r    <= duty_valid ? duty_in_s : shadow_r;
                active_dt_r <= duty_valid ? dead_time : shadow_dt_r;
            end else begin
                active_r    <= active_r;
                active_dt_r <= active_dt_r;
            end
            sync_r <= valley_s;
        end
    end

    assign raw_s[0] = (cnt_r < active_r.a);
    assign raw_s[1] = (cnt_r < active_r.b);
    assign raw_s[2] = (cnt_r < active_r.c);
    assign sync     = sync_r;

    deadtime_unit #(.DT_W(DT_W)) u_dt_a (
        .clk(clk), .rst(rst), .enable(enable), .raw(raw_s[0]),
        .dead_time(active_dt_r), .h(ah), .l(al)
    );

    deadtime_unit #(.DT_W(DT_W)) u_dt_b (
        .clk(clk), .rst(rst), .enable(enable), .raw(raw_s[1]),
        .dead_time(active_dt_r), .h(bh), .l(bl)
    );

    deadtime_unit #(.DT_W(DT_W)) u_dt_c (
        .clk(clk), .rst(rst), .enable(enable), .raw(raw_s[2]),
        .dead_time(active_dt_r), .h(ch), .l(cl)
    );

endmodule
